cpu_clock_ctrl: RTL

//  Sequences the 8-bit CPU's execution clock. Produces a single-CLK-cycle

---
 rtl/cpu_pkg.sv | 17 +
 rtl/cpu_clock_ctrl_btn_debounce.sv | 46 ++++
 rtl/cpu_clock_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the CPU clock controller.
// FSM state encoding and speed-select codes.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_STOP = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_HALT = 2'b11
  } state_t;

  localparam logic [1:0] SPD_1X  = 2'd0;
  localparam logic [1:0] SPD_4X  = 2'd1;
  localparam logic [1:0] SPD_16X = 2'd2;
  localparam logic [1:0] SPD_64X = 2'd3;

endpackage

// File: rtl/cpu_clock_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop sync, stability filter, rise pulse.
// Ports: CLK, CLRn, btn (raw), step_req (1-cycle pulse on debounced press).
module btn_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic CLK,
  input  logic CLRn,
  input  logic btn,
  output logic step_req
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          s1;
  logic          s2;
  logic          level;
  logic          prev;
  logic [CW-1:0] cnt;

  // cnt counts consecutive samples that disagree with the
  // accepted level; any agreeing sample restarts the run.
  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      level    <= 1'b0;
      prev     <= 1'b0;
      step_req <= 1'b0;
      cnt      <= '0;
    end else begin
      s1       <= btn;
      s2       <= s1;
      prev     <= level;
      step_req <= level & ~prev;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_clock_ctrl.sv
// CPU clock-enable sequencer: free-run, single-step and halt modes.
// Ports: CLK, CLRn, run_sw, step_btn, speed_sel, halt -> cpu_ce, clk_led, state, halted.
import cpu_pkg::*;

module cpu_clock_ctrl #(
  parameter int CNT_W     = 28,
  parameter int TICK_DIV  = 50_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       CLK,
  input  logic       CLRn,
  input  logic       run_sw,
  input  logic       step_btn,
  input  logic [1:0] speed_sel,
  input  logic       halt,
  output logic       cpu_ce,
  output logic       clk_led,
  output logic [1:0] state,
  output logic       halted
);

  localparam logic [CNT_W-1:0] DIV = CNT_W'(TICK_DIV);

  logic             run_s1;
  logic             run_sync;
  logic             step_req;
  state_t           state_q;
  state_t           state_n;
  logic [CNT_W-1:0] presc;
  logic [CNT_W-1:0] presc_n;
  logic [CNT_W-1:0] lim_raw;
  logic [CNT_W-1:0] limit;
  logic             ce_n;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_step_db (
    .CLK     (CLK),
    .CLRn    (CLRn),
    .btn     (step_btn),
    .step_req(step_req)
  );

  // Fast speeds can shift the divider to zero; clamp to one
  // so the CPU then steps every cycle.
  always_comb begin
    lim_raw = DIV >> {speed_sel, 1'b0};
    limit   = (lim_raw == '0) ? CNT_W'(1) : lim_raw;
  end

  // >= rather than == so a lowered limit ticks at once.
  always_comb begin
    state_n = state_q;
    presc_n = '0;
    ce_n    = 1'b0;
    unique case (state_q)
      S_STOP: begin
        if (halt)          state_n = S_HALT;
        else if (run_sync) state_n = S_RUN;
        else if (step_req) state_n = S_STEP;
      end
      S_RUN: begin
        if (halt)
          state_n = S_HALT;
        else if (!run_sync)
          state_n = S_STOP;
        else if (presc >= limit - CNT_W'(1))
          ce_n = 1'b1;
        else
          presc_n = presc + CNT_W'(1);
      end
      S_STEP: begin
        state_n = halt ? S_HALT : S_STOP;
      end
      S_HALT: begin
        state_n = S_HALT;
      end
    endcase
    if (state_n == S_STEP) ce_n = 1'b1;
  end

  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      run_s1   <= 1'b0;
      run_sync <= 1'b0;
      state_q  <= S_STOP;
      presc    <= '0;
      cpu_ce   <= 1'b0;
      clk_led  <= 1'b0;
      halted   <= 1'b0;
    end else begin
      run_s1   <= run_sw;
      run_sync <= run_s1;
      state_q  <= state_n;
      presc    <= presc_n;
      cpu_ce   <= ce_n;
      clk_led  <= clk_led ^ ce_n;
      halted   <= (state_n == S_HALT);
    end
  end

  assign state = state_q;

endmodule
